// File: rtl/sht40_i2c_target_pkg.sv
// Shared constants for the SHT40 I2C target emulator: FSM encodings,
// I2C acknowledge levels and the CRC-8 parameters used on result words.
package sht40_i2c_target_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ADDR     = 3'd1;
  localparam logic [2:0] ST_ADDR_ACK = 3'd2;
  localparam logic [2:0] ST_CMD      = 3'd3;
  localparam logic [2:0] ST_CMD_ACK  = 3'd4;
  localparam logic [2:0] ST_TX_BYTE  = 3'd5;
  localparam logic [2:0] ST_TX_ACK   = 3'd6;
  localparam logic [2:0] ST_IGNORE   = 3'd7;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [7:0] CRC_POLY = 8'h31;
  localparam logic [7:0] CRC_INIT = 8'hFF;

  // Number of bytes in one measurement result (T_MSB..RH_CRC)
  localparam logic [2:0] RESULT_BYTES = 3'd6;

endpackage

// File: rtl/sht40_i2c_target_if.sv
// Sensor-side signal bundle of the SHT40 emulator: raw measurement words
// going in, command/measurement status coming out.
interface sht40_i2c_target_if;
  logic [15:0] Temp_Word;
  logic [15:0] RH_Word;
  logic [7:0]  Cmd_Received;
  logic        Cmd_Valid;
  logic        Meas_Busy;
  logic [2:0]  Bytes_Sent;

  modport master (
    output Temp_Word, RH_Word,
    input  Cmd_Received, Cmd_Valid, Meas_Busy, Bytes_Sent
  );

  modport slave (
    input  Temp_Word, RH_Word,
    output Cmd_Received, Cmd_Valid, Meas_Busy, Bytes_Sent
  );
endinterface

// File: rtl/sht_crc8.sv
// Combinational Sensirion CRC-8 over one 16-bit word, MSB first
// (poly 0x31, init 0xFF, no reflection, no final XOR).
module sht_crc8
  import sht40_i2c_target_pkg::*;
(
  input  logic [15:0] i_word,
  output logic [7:0]  o_crc
);

  // Bit-serial CRC unrolled over the 16 word bits
  always_comb begin
    o_crc = CRC_INIT;
    for (int i = 15; i >= 0; i--) begin
      o_crc = {o_crc[6:0], 1'b0} ^ (((o_crc[7] ^ i_word[i]) == 1'b1) ? CRC_POLY : 8'h00);
    end
  end

endmodule

// File: rtl/sht40_i2c_target.sv
// SHT40 sensor stand-in on an I2C bus: accepts address+command writes,
// runs a timed measurement on CMD_MEAS and serves the 6-byte result
// (T_MSB, T_LSB, T_CRC, RH_MSB, RH_LSB, RH_CRC) once on a read.
module sht40_i2c_target
  import sht40_i2c_target_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h44,
  parameter logic [7:0]  CMD_MEAS    = 8'hFD,
  parameter logic [15:0] MEAS_CYCLES = 16'd2000
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                Scl_Data,
  inout  wire                 Sda_Data,
  sht40_i2c_target_if.slave   sns
);

  logic        r_scl_p0, r_scl_p1, r_scl_p2;
  logic        r_sda_p0, r_sda_p1, r_sda_p2;
  logic [2:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [6:0]  r_shift;
  logic [47:0] r_tx_img;
  logic        r_sda_low;
  logic        r_ack_on;
  logic        r_rw;
  logic        r_cmd_done;
  logic        r_rd_active;
  logic        r_data_ready;
  logic [2:0]  r_bytes_sent;
  logic [7:0]  r_cmd;
  logic        r_cmd_valid;
  logic        r_meas_busy;
  logic [15:0] r_meas_cnt;

  logic        w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]  w_byte;
  logic        w_byte_done;
  logic        w_meas_start, w_meas_end;
  logic        w_tx_shift;
  logic [7:0]  w_crc_t, w_crc_rh;

  sht_crc8 u_crc_t  (.i_word(sns.Temp_Word), .o_crc(w_crc_t));
  sht_crc8 u_crc_rh (.i_word(sns.RH_Word),   .o_crc(w_crc_rh));

  // Bus event decode on the synchronized pins
  assign w_scl_rise  = r_scl_p1 & ~r_scl_p2;
  assign w_scl_fall  = ~r_scl_p1 & r_scl_p2;
  assign w_start     = r_scl_p1 & r_scl_p2 & ~r_sda_p1 & r_sda_p2;
  assign w_stop      = r_scl_p1 & r_scl_p2 & r_sda_p1 & ~r_sda_p2;
  assign w_byte      = {r_shift, r_sda_p1};
  assign w_byte_done = w_scl_rise && (r_bit_cnt == 3'd7);

  // First command byte of a write starts a measurement unless one is running
  assign w_meas_start = (r_state == ST_CMD) && w_byte_done && !r_cmd_done &&
                        (w_byte == CMD_MEAS) && !r_meas_busy;
  assign w_meas_end   = r_meas_busy && (r_meas_cnt == 16'd1);
  // The transmit image moves one bit on every SCL fall of a data byte,
  // including the fall after bit 8 which brings up the next byte's MSB
  assign w_tx_shift   = w_scl_fall && ((r_state == ST_TX_BYTE) ||
                        ((r_state == ST_TX_ACK) && !r_ack_on));

  assign Sda_Data         = r_sda_low ? 1'b0 : 1'bz;
  assign sns.Cmd_Received = r_cmd;
  assign sns.Cmd_Valid    = r_cmd_valid;
  assign sns.Meas_Busy    = r_meas_busy;
  assign sns.Bytes_Sent   = r_bytes_sent;

  // Two-flop synchronizers plus a previous-value stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_p0 <= 1'b1; r_scl_p1 <= 1'b1; r_scl_p2 <= 1'b1;
      r_sda_p0 <= 1'b1; r_sda_p1 <= 1'b1; r_sda_p2 <= 1'b1;
    end else begin
      r_scl_p0 <= Scl_Data; r_scl_p1 <= r_scl_p0; r_scl_p2 <= r_scl_p1;
      r_sda_p0 <= Sda_Data; r_sda_p1 <= r_sda_p0; r_sda_p2 <= r_sda_p1;
    end
  end

  // Measurement timer: Meas_Busy stays high for exactly MEAS_CYCLES clocks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meas_busy <= 1'b0;
      r_meas_cnt  <= 16'd0;
    end else if (w_meas_start) begin
      r_meas_busy <= 1'b1;
      r_meas_cnt  <= MEAS_CYCLES;
    end else if (r_meas_busy) begin
      r_meas_cnt <= r_meas_cnt - 16'd1;
      if (r_meas_cnt == 16'd1) r_meas_busy <= 1'b0;
    end
  end

  // Receive shifter and 48-bit result image (datapath, no reset needed)
  always_ff @(posedge clk) begin
    if (w_scl_rise && ((r_state == ST_ADDR) || (r_state == ST_CMD)))
      r_shift <= w_byte[6:0];
    if (w_meas_end)
      r_tx_img <= {sns.Temp_Word, w_crc_t, sns.RH_Word, w_crc_rh};
    else if (w_tx_shift)
      r_tx_img <= {r_tx_img[46:0], 1'b0};
  end

  // Protocol FSM: address/command decode, ACK windows, result transmit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= 3'd0;
      r_sda_low    <= 1'b0;
      r_ack_on     <= 1'b0;
      r_rw         <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_rd_active  <= 1'b0;
      r_data_ready <= 1'b0;
      r_bytes_sent <= 3'd0;
      r_cmd        <= 8'h00;
      r_cmd_valid  <= 1'b0;
    end else begin
      r_cmd_valid <= 1'b0;
      if (w_start || w_stop) begin
        // A read that delivered anything consumes the result
        if (r_rd_active && (r_bytes_sent != 3'd0)) r_data_ready <= 1'b0;
        r_rd_active <= 1'b0;
        r_sda_low   <= 1'b0;
        r_ack_on    <= 1'b0;
        r_bit_cnt   <= 3'd0;
        r_state     <= w_start ? ST_ADDR : ST_IDLE;
      end else begin
        case (r_state)
          ST_ADDR: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (w_byte[7:1] != DEV_ADDR) begin
                  r_state <= ST_IGNORE;
                end else if (!w_byte[0]) begin
                  r_rw    <= 1'b0;
                  r_state <= ST_ADDR_ACK;
                end else if (r_data_ready && !r_meas_busy) begin
                  r_rw         <= 1'b1;
                  r_bytes_sent <= 3'd0;
                  r_rd_active  <= 1'b1;
                  r_state      <= ST_ADDR_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end
          ST_ADDR_ACK, ST_CMD_ACK: begin
            if (w_scl_fall) begin
              if (!r_ack_on) begin
                r_sda_low <= ~ACK;
                r_ack_on  <= 1'b1;
              end else begin
                r_ack_on  <= 1'b0;
                r_bit_cnt <= 3'd0;
                if ((r_state == ST_ADDR_ACK) && r_rw) begin
                  r_sda_low <= ~r_tx_img[47];
                  r_state   <= ST_TX_BYTE;
                end else begin
                  r_sda_low <= 1'b0;
                  if (r_state == ST_ADDR_ACK) r_cmd_done <= 1'b0;
                  r_state   <= ST_CMD;
                end
              end
            end
          end
          ST_CMD: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                if (!r_cmd_done) begin
                  r_cmd       <= w_byte;
                  r_cmd_valid <= 1'b1;
                  r_cmd_done  <= 1'b1;
                  r_state     <= ST_CMD_ACK;
                end else begin
                  r_state <= ST_IGNORE;
                end
              end
            end
          end
          ST_TX_BYTE: begin
            if (w_scl_rise) begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
              if (r_bit_cnt == 3'd7) begin
                r_bytes_sent <= r_bytes_sent + 3'd1;
                r_state      <= ST_TX_ACK;
              end
            end else if (w_scl_fall) begin
              r_sda_low <= ~r_tx_img[46];
            end
          end
          ST_TX_ACK: begin
            if (w_scl_fall && !r_ack_on) begin
              r_sda_low <= 1'b0;
              r_ack_on  <= 1'b1;
            end else if (w_scl_rise && r_ack_on) begin
              if ((r_sda_p1 == NACK) || (r_bytes_sent == RESULT_BYTES)) begin
                r_ack_on <= 1'b0;
                r_state  <= ST_IGNORE;
              end
            end else if (w_scl_fall && r_ack_on) begin
              r_ack_on  <= 1'b0;
              r_bit_cnt <= 3'd0;
              r_sda_low <= ~r_tx_img[47];
              r_state   <= ST_TX_BYTE;
            end
          end
          default: ;
        endcase
      end
      // Measurement bookkeeping for the read-once result
      if (w_meas_start) r_data_ready <= 1'b0;
      if (w_meas_end)   r_data_ready <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sht40_i2c_target.sv
// Directed bench for the SHT40 I2C target: a bit-banged I2C master drives
// the bus, expected bytes and CRCs are hand-computed constants.
module tb_sht40_i2c_target;
  import sht40_i2c_target_pkg::*;

  localparam int MEAS = 1000;
  localparam int T    = 50;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  sda;

  int n_tests = 0;
  int n_fail  = 0;
  int cv_hi   = 0;
  int busy_hi = 0;

  always #5 clk = ~clk;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  sht40_i2c_target_if sif ();

  sht40_i2c_target #(
    .DEV_ADDR   (7'h44),
    .CMD_MEAS   (8'hFD),
    .MEAS_CYCLES(16'(MEAS))
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .Scl_Data(scl),
    .Sda_Data(sda),
    .sns     (sif)
  );

  always @(negedge clk) begin
    if (sif.Cmd_Valid) cv_hi++;
    if (sif.Meas_Busy) busy_hi++;
  end

  task automatic chk(input string tag, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic i2c_start();
    m_low = 1'b0; #(2*T);
    scl = 1'b1;   #(2*T);
    m_low = 1'b1; #(2*T);
    scl = 1'b0;   #(T);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; #(2*T);
    scl = 1'b1;   #(2*T);
    m_low = 1'b0; #(2*T);
  endtask

  task automatic write_bit(input logic b);
    m_low = ~b; #(2*T);
    scl = 1'b1; #(2*T);
    scl = 1'b0; #(T);
  endtask

  task automatic read_bit(output logic b);
    m_low = 1'b0; #(2*T);
    scl = 1'b1;   #(T);
    b = sda;      #(T);
    scl = 1'b0;   #(T);
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(ack);
  endtask

  task automatic read_byte(output logic [7:0] d);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      d[i] = v;
    end
  endtask

  task automatic wait_busy_end();
    int k;
    k = 0;
    while (sif.Meas_Busy && k < 5000) begin
      @(negedge clk);
      k++;
    end
    chk("busy_end", 48'(sif.Meas_Busy), 48'h0);
  endtask

  task automatic write_cmd(input string tag);
    logic ack;
    i2c_start();
    write_byte(8'h88, ack);
    chk({tag, "_addr_ack"}, 48'(ack), 48'h0);
    write_byte(8'hFD, ack);
    chk({tag, "_cmd_ack"}, 48'(ack), 48'h0);
    i2c_stop();
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin : stim
    logic       ack;
    logic [7:0] b;
    int         cvb, bb;
    logic [7:0] exp3 [6];
    logic [7:0] exp6 [6];
    exp3 = '{8'hBE, 8'hEF, 8'h92, 8'hBE, 8'hEF, 8'h92};
    exp6 = '{8'h00, 8'h00, 8'h81, 8'hBE, 8'hEF, 8'h92};

    sif.Temp_Word = 16'hBEEF;
    sif.RH_Word   = 16'hBEEF;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_sda",   48'(sda), 48'h1);
    chk("rst_cmd",   48'(sif.Cmd_Received), 48'h0);
    chk("rst_cv",    48'(sif.Cmd_Valid), 48'h0);
    chk("rst_busy",  48'(sif.Meas_Busy), 48'h0);
    chk("rst_bytes", 48'(sif.Bytes_Sent), 48'h0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: measurement command
    cvb = cv_hi;
    bb  = busy_hi;
    write_cmd("t1");
    chk("t1_cmd",  48'(sif.Cmd_Received), 48'hFD);
    chk("t1_cv",   48'(cv_hi - cvb), 48'h1);
    chk("t1_busy", 48'(sif.Meas_Busy), 48'h1);

    // 2: read while busy is refused and the target stays off the bus
    i2c_start();
    write_byte(8'h89, ack);
    chk("t2_nack", 48'(ack), 48'h1);
    read_byte(b);
    chk("t2_released", 48'(b), 48'hFF);
    i2c_stop();

    wait_busy_end();
    chk("t1_busy_len", 48'(busy_hi - bb), 48'(MEAS));

    // 3: full result read of 0xBEEF / 0xBEEF
    i2c_start();
    write_byte(8'h89, ack);
    chk("t3_addr_ack", 48'(ack), 48'h0);
    for (int i = 0; i < 6; i++) begin
      read_byte(b);
      chk($sformatf("t3_byte%0d", i), 48'(b), 48'(exp3[i]));
      write_bit(i == 5);
    end
    chk("t3_bytes", 48'(sif.Bytes_Sent), 48'h6);
    i2c_stop();
    chk("t3_bytes_after_stop", 48'(sif.Bytes_Sent), 48'h6);
    i2c_start();
    write_byte(8'h89, ack);
    chk("t3_reread_nack", 48'(ack), 48'h1);
    i2c_stop();

    // 4: other address is ignored entirely
    cvb = cv_hi;
    i2c_start();
    write_byte(8'h8A, ack);
    chk("t4_addr_nack", 48'(ack), 48'h1);
    write_byte(8'hFD, ack);
    chk("t4_cmd_nack", 48'(ack), 48'h1);
    i2c_stop();
    chk("t4_cv",   48'(cv_hi - cvb), 48'h0);
    chk("t4_busy", 48'(sif.Meas_Busy), 48'h0);

    // 5: master NACK after two bytes, then the result is consumed
    write_cmd("t5");
    wait_busy_end();
    i2c_start();
    write_byte(8'h89, ack);
    chk("t5_addr_ack", 48'(ack), 48'h0);
    read_byte(b);
    chk("t5_byte0", 48'(b), 48'hBE);
    write_bit(1'b0);
    read_byte(b);
    chk("t5_byte1", 48'(b), 48'hEF);
    write_bit(1'b1);
    chk("t5_bytes", 48'(sif.Bytes_Sent), 48'h2);
    m_low = 1'b0;
    repeat (10) @(negedge clk);
    chk("t5_released", 48'(sda), 48'h1);
    i2c_start();
    write_byte(8'h89, ack);
    chk("t5_rs_nack", 48'(ack), 48'h1);
    i2c_stop();

    // 6: reset while the target drives a data 0, then recovery
    sif.Temp_Word = 16'h0000;
    sif.RH_Word   = 16'hBEEF;
    write_cmd("t6a");
    wait_busy_end();
    i2c_start();
    write_byte(8'h89, ack);
    chk("t6_addr_ack", 48'(ack), 48'h0);
    chk("t6_tx_low", 48'(sda), 48'h0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_sda",   48'(sda), 48'h1);
    chk("t6_rst_cmd",   48'(sif.Cmd_Received), 48'h0);
    chk("t6_rst_cv",    48'(sif.Cmd_Valid), 48'h0);
    chk("t6_rst_busy",  48'(sif.Meas_Busy), 48'h0);
    chk("t6_rst_bytes", 48'(sif.Bytes_Sent), 48'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    i2c_stop();
    cvb = cv_hi;
    write_cmd("t6b");
    chk("t6_cmd",  48'(sif.Cmd_Received), 48'hFD);
    chk("t6_cv",   48'(cv_hi - cvb), 48'h1);
    chk("t6_busy", 48'(sif.Meas_Busy), 48'h1);
    wait_busy_end();
    i2c_start();
    write_byte(8'h89, ack);
    chk("t6_read_ack", 48'(ack), 48'h0);
    for (int i = 0; i < 6; i++) begin
      read_byte(b);
      chk($sformatf("t6_byte%0d", i), 48'(b), 48'(exp6[i]));
      write_bit(i == 5);
    end
    i2c_stop();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
